ssd_scan_scheduler: RTL and testbench

Time-multiplexing scheduler for the 4-digit seven-segment display in the stopwatch design. It generates the 2-bit `refresh_count` slot index consumed by the anode decoder and selects the BCD digit for the current slot from a frame-coherent snapshot of the displayed value. It inserts a per-slot blanking interval against ghosting, applies optional leading-zero suppression and drives the active-low decimal point. It sits between the stopwatch counter (value source) and the anode decoder / segment decoder pair.

---
 rtl/ssd_scan_scheduler_if.sv | 24 ++
 rtl/ssd_scan_scheduler.sv | 122 ++++++++++++
 tb/tb_ssd_scan_scheduler.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ssd_scan_scheduler_if.sv
// Bus between the stopwatch value source, the seven-segment scan scheduler and
// the anode/segment decoders.
interface ssd_scan_scheduler_if;
  logic        en;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic        lz_suppress;
  logic [1:0]  refresh_count;
  logic [3:0]  digit_bcd;
  logic        digit_blank;
  logic        anode_en;
  logic        dp_n;
  logic        frame_tick;

  modport master (
    output en, value, dp_mask, lz_suppress,
    input  refresh_count, digit_bcd, digit_blank, anode_en, dp_n, frame_tick
  );

  modport slave (
    input  en, value, dp_mask, lz_suppress,
    output refresh_count, digit_bcd, digit_blank, anode_en, dp_n, frame_tick
  );
endinterface

// File: rtl/ssd_scan_scheduler.sv
// Four-digit seven-segment scan scheduler: slot sequencing, per-slot blanking,
// frame-coherent value snapshot, leading-zero suppression and decimal point.
module ssd_scan_scheduler #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input logic                 clk,
  input logic                 rst_n,
  ssd_scan_scheduler_if.slave bus
);

  localparam int unsigned cnt_w = $clog2(REFRESH_DIV);
  localparam logic [cnt_w-1:0] slot_last = cnt_w'(REFRESH_DIV - 32'd1);
  localparam logic [cnt_w-1:0] blank_last =
    cnt_w'((BLANK_CYCLES == 32'd0) ? 32'd0 : BLANK_CYCLES - 32'd1);
  localparam bit no_blank = (BLANK_CYCLES == 32'd0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t           state;
  state_t           nxt_state;
  logic [cnt_w-1:0] slot_cnt;
  logic [cnt_w-1:0] nxt_cnt;
  logic [1:0]       rc;
  logic [1:0]       nxt_rc;
  logic [15:0]      snap;
  logic [15:0]      nxt_snap;
  logic             nxt_tick;
  logic [3:0]       nxt_digit;
  logic             nxt_suppress;

  // Transition decisions; outputs are registered from these next values so
  // they always match the state being entered.
  always_comb begin : next_values
    nxt_state = state;
    nxt_cnt   = slot_cnt;
    nxt_rc    = rc;
    nxt_snap  = snap;
    nxt_tick  = 1'b0;
    if (state == IDLE) begin
      if (bus.en) begin
        nxt_state = no_blank ? SHOW : BLANK;
        nxt_cnt   = '0;
        nxt_rc    = 2'd0;
        nxt_snap  = bus.value;
      end
    end else if (!bus.en) begin
      nxt_state = IDLE;
      nxt_cnt   = '0;
    end else begin
      nxt_cnt = (slot_cnt == slot_last) ? '0 : cnt_w'(slot_cnt + cnt_w'(1));
      if (state == BLANK) begin
        if (slot_cnt == blank_last) begin
          nxt_state = SHOW;
        end
      end else if (slot_cnt == slot_last) begin
        nxt_state = no_blank ? SHOW : BLANK;
        nxt_rc    = 2'(rc + 2'd1);
        // Slot 3 -> slot 0 is the frame boundary: refresh the snapshot here only.
        if (rc == 2'd3) begin
          nxt_snap = bus.value;
          nxt_tick = 1'b1;
        end
      end
    end
  end

  // Digit select and leading-zero suppression for the slot being entered.
  always_comb begin : digit_decode
    nxt_digit    = 4'd0;
    nxt_suppress = 1'b0;
    case (nxt_rc)
      2'd0: begin
        nxt_digit    = nxt_snap[3:0];
        nxt_suppress = 1'b0;
      end
      2'd1: begin
        nxt_digit    = nxt_snap[7:4];
        nxt_suppress = bus.lz_suppress && (nxt_snap[15:4] == 12'd0);
      end
      2'd2: begin
        nxt_digit    = nxt_snap[11:8];
        nxt_suppress = bus.lz_suppress && (nxt_snap[15:8] == 8'd0);
      end
      default: begin
        nxt_digit    = nxt_snap[15:12];
        nxt_suppress = bus.lz_suppress && (nxt_snap[15:12] == 4'd0);
      end
    endcase
  end

  always_ff @(posedge clk) begin : fsm
    if (!rst_n) begin
      state           <= IDLE;
      slot_cnt        <= '0;
      rc              <= 2'd0;
      snap            <= 16'd0;
      bus.digit_bcd   <= 4'd0;
      bus.digit_blank <= 1'b1;
      bus.anode_en    <= 1'b0;
      bus.dp_n        <= 1'b1;
      bus.frame_tick  <= 1'b0;
    end else begin
      state           <= nxt_state;
      slot_cnt        <= nxt_cnt;
      rc              <= nxt_rc;
      snap            <= nxt_snap;
      bus.digit_bcd   <= nxt_digit;
      bus.digit_blank <= (nxt_state != SHOW) || nxt_suppress;
      bus.anode_en    <= (nxt_state == SHOW);
      bus.dp_n        <= (nxt_state == SHOW) ? ~bus.dp_mask[nxt_rc] : 1'b1;
      bus.frame_tick  <= nxt_tick;
    end
  end

  assign bus.refresh_count = rc;

endmodule

// File: tb/tb_ssd_scan_scheduler.sv
// Directed bench for ssd_scan_scheduler: one blanking instance (8/2) and one
// without blanking (8/0) sharing clock and reset.
module tb_ssd_scan_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  ssd_scan_scheduler_if bus();
  ssd_scan_scheduler_if bus_nb();

  ssd_scan_scheduler #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  ssd_scan_scheduler #(.REFRESH_DIV(8), .BLANK_CYCLES(0)) dut_nb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_nb.slave)
  );

  // {refresh_count, digit_bcd, digit_blank, anode_en, dp_n, frame_tick}
  function automatic logic [9:0] obs_main();
    return {bus.refresh_count, bus.digit_bcd, bus.digit_blank,
            bus.anode_en, bus.dp_n, bus.frame_tick};
  endfunction

  function automatic logic [9:0] obs_nb();
    return {bus_nb.refresh_count, bus_nb.digit_bcd, bus_nb.digit_blank,
            bus_nb.anode_en, bus_nb.dp_n, bus_nb.frame_tick};
  endfunction

  function automatic logic [3:0] nib(input logic [15:0] v, input int s);
    return v[s*4 +: 4];
  endfunction

  // Called at a falling edge; the next falling edge is the first cycle after enable.
  task automatic restart(input logic [15:0] v);
    bus.en = 1'b0;
    @(negedge clk);
    bus.value = v;
    bus.en    = 1'b1;
  endtask

  task automatic test_reset();
    logic [9:0] got;
    bus.en = 1'b1; bus.value = 16'h1234; bus.dp_mask = 4'b0000; bus.lz_suppress = 1'b0;
    bus_nb.en = 1'b0; bus_nb.value = 16'h1234; bus_nb.dp_mask = 4'b0000; bus_nb.lz_suppress = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    got = obs_main();
    n_tests++;
    if (got !== 10'b00_0000_1_0_1_0) begin
      n_fail++; $display("FAIL reset_main got %b want %b", got, 10'b00_0000_1_0_1_0);
    end
    got = obs_nb();
    n_tests++;
    if (got !== 10'b00_0000_1_0_1_0) begin
      n_fail++; $display("FAIL reset_nb got %b want %b", got, 10'b00_0000_1_0_1_0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    got = obs_main();
    n_tests++;
    if (got !== 10'b00_0100_1_0_1_0) begin
      n_fail++; $display("FAIL reset_release_blank got %b want %b", got, 10'b00_0100_1_0_1_0);
    end
    bus.en = 1'b0;
    @(negedge clk);
    got = obs_main();
    n_tests++;
    if (got !== 10'b00_0100_1_0_1_0) begin
      n_fail++; $display("FAIL reset_then_idle got %b want %b", got, 10'b00_0100_1_0_1_0);
    end
  endtask

  task automatic test_basic_scan();
    logic [9:0] got;
    logic [9:0] want;
    restart(16'h1234);
    for (int k = 0; k <= 32; k++) begin
      int s;
      int p;
      @(negedge clk);
      s = (k / 8) % 4;
      p = k % 8;
      want = {2'(s), nib(16'h1234, s), 1'(p < 2), 1'(p >= 2), 1'b1, 1'(k == 32)};
      got  = obs_main();
      n_tests++;
      if (got !== want) begin
        n_fail++; $display("FAIL basic_scan k=%0d got %b want %b", k, got, want);
      end
    end
  endtask

  task automatic test_snapshot();
    logic [9:0] got;
    logic [9:0] want;
    restart(16'h1234);
    for (int k = 0; k <= 40; k++) begin
      int s;
      int p;
      logic [15:0] shown;
      @(negedge clk);
      s = (k / 8) % 4;
      p = k % 8;
      shown = (k < 32) ? 16'h1234 : 16'h5678;
      want = {2'(s), nib(shown, s), 1'(p < 2), 1'(p >= 2), 1'b1, 1'(k == 32)};
      got  = obs_main();
      n_tests++;
      if (got !== want) begin
        n_fail++; $display("FAIL snapshot k=%0d got %b want %b", k, got, want);
      end
      if (k == 9) bus.value = 16'h5678;
    end
  endtask

  task automatic test_lz_suppress();
    logic [15:0] pats  [2] = '{16'h0040, 16'h0000};
    logic [3:0]  masks [2] = '{4'b1100, 4'b1110};
    logic [9:0]  got;
    logic [9:0]  want;
    bus.lz_suppress = 1'b1;
    for (int t = 0; t < 2; t++) begin
      restart(pats[t]);
      for (int k = 0; k < 32; k++) begin
        int s;
        int p;
        logic [3:0] m;
        @(negedge clk);
        s = k / 8;
        p = k % 8;
        m = masks[t];
        want = {2'(s), nib(pats[t], s), 1'((p < 2) || m[s]), 1'(p >= 2), 1'b1, 1'b0};
        got  = obs_main();
        n_tests++;
        if (got !== want) begin
          n_fail++; $display("FAIL lz_suppress pat=%h k=%0d got %b want %b", pats[t], k, got, want);
        end
      end
    end
    bus.lz_suppress = 1'b0;
  endtask

  task automatic test_decimal_point();
    logic [9:0] got;
    logic [9:0] want;
    bus.dp_mask = 4'b0100;
    restart(16'h1234);
    for (int k = 0; k < 32; k++) begin
      int s;
      int p;
      @(negedge clk);
      s = k / 8;
      p = k % 8;
      want = {2'(s), nib(16'h1234, s), 1'(p < 2), 1'(p >= 2), 1'(!(s == 2 && p >= 2)), 1'b0};
      got  = obs_main();
      n_tests++;
      if (got !== want) begin
        n_fail++; $display("FAIL decimal_point k=%0d got %b want %b", k, got, want);
      end
    end
    bus.dp_mask = 4'b0000;
  endtask

  task automatic test_enable_mid_slot();
    logic [9:0] got;
    restart(16'h1234);
    repeat (22) @(negedge clk);
    got = obs_main();
    n_tests++;
    if (got !== 10'b10_0010_0_1_1_0) begin
      n_fail++; $display("FAIL en_mid_before got %b want %b", got, 10'b10_0010_0_1_1_0);
    end
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got = obs_main();
      n_tests++;
      if (got !== 10'b10_0010_1_0_1_0) begin
        n_fail++; $display("FAIL en_mid_idle i=%0d got %b want %b", i, got, 10'b10_0010_1_0_1_0);
      end
    end
    bus.value = 16'h9876;
    bus.en    = 1'b1;
    @(negedge clk);
    got = obs_main();
    n_tests++;
    if (got !== 10'b00_0110_1_0_1_0) begin
      n_fail++; $display("FAIL en_reraise_k0 got %b want %b", got, 10'b00_0110_1_0_1_0);
    end
    repeat (2) @(negedge clk);
    got = obs_main();
    n_tests++;
    if (got !== 10'b00_0110_0_1_1_0) begin
      n_fail++; $display("FAIL en_reraise_k2 got %b want %b", got, 10'b00_0110_0_1_1_0);
    end
    repeat (8) @(negedge clk);
    got = obs_main();
    n_tests++;
    if (got !== 10'b01_0111_0_1_1_0) begin
      n_fail++; $display("FAIL en_reraise_k10 got %b want %b", got, 10'b01_0111_0_1_1_0);
    end
  endtask

  task automatic test_reset_mid_slot();
    logic [9:0] got;
    restart(16'h1234);
    repeat (22) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    got = obs_main();
    n_tests++;
    if (got !== 10'b00_0000_1_0_1_0) begin
      n_fail++; $display("FAIL rst_mid got %b want %b", got, 10'b00_0000_1_0_1_0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    got = obs_main();
    n_tests++;
    if (got !== 10'b00_0100_1_0_1_0) begin
      n_fail++; $display("FAIL rst_mid_restart got %b want %b", got, 10'b00_0100_1_0_1_0);
    end
    repeat (2) @(negedge clk);
    got = obs_main();
    n_tests++;
    if (got !== 10'b00_0100_0_1_1_0) begin
      n_fail++; $display("FAIL rst_mid_show got %b want %b", got, 10'b00_0100_0_1_1_0);
    end
    bus.en = 1'b0;
  endtask

  task automatic test_no_blank();
    logic [9:0] got;
    logic [9:0] want;
    bus_nb.value = 16'h1234;
    bus_nb.en    = 1'b1;
    for (int k = 0; k <= 32; k++) begin
      int s;
      @(negedge clk);
      s = (k / 8) % 4;
      want = {2'(s), nib(16'h1234, s), 1'b0, 1'b1, 1'b1, 1'(k == 32)};
      got  = obs_nb();
      n_tests++;
      if (got !== want) begin
        n_fail++; $display("FAIL no_blank k=%0d got %b want %b", k, got, want);
      end
    end
    bus_nb.en = 1'b0;
    @(negedge clk);
    got = obs_nb();
    n_tests++;
    if (got !== 10'b00_0100_1_0_1_0) begin
      n_fail++; $display("FAIL no_blank_disable got %b want %b", got, 10'b00_0100_1_0_1_0);
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_snapshot();
    test_lz_suppress();
    test_decimal_point();
    test_enable_mid_slot();
    test_reset_mid_slot();
    test_no_blank();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
